// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard / stall logic.
package hazard_pkg;

  // Multiply/divide unit occupancy states.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Defaults that match the classic MIPS datapath (32 registers, rs/rt).
  localparam int DEF_REG_W   = 5;
  localparam int DEF_NUM_SRC = 2;

  // $zero never carries a real dependency.
  localparam logic [DEF_REG_W-1:0] REG_ZERO = '0;

  // Width of a down-counter that must hold values 0 .. n-1, never zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_tracker.sv
// Multiply/divide occupancy tracker: the HI/LO unit stays busy for MD_LAT
// cycles after it accepts an instruction.
//
// state   | meaning
// MD_IDLE | unit free, may accept start
// MD_BUSY | unit computing, md_cnt counts remaining cycles down to 0
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int              MD_W    = cnt_width(MD_LAT);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT - 1);

  md_state_t       md_state;
  logic [MD_W-1:0] md_cnt;

  // Occupancy FSM; the start edge loads MD_LAT-1 and the unit frees at the
  // edge where the count is already 0, giving exactly MD_LAT busy cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (start) begin
            md_state <= MD_BUSY;
            md_cnt   <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          if (md_cnt == '0) begin
            md_state <= MD_IDLE;
          end else begin
            md_cnt <= md_cnt - MD_W'(1);
          end
        end
        default: begin
          md_state <= MD_IDLE;
          md_cnt   <= '0;
        end
      endcase
    end
  end

  // Busy is a pure decode of the registered state.
  assign busy = (md_state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: load-use stall with configurable load latency,
// HI/LO multiply/divide interlock, pipeline write enables, ID/EXE bubble
// injection and a saturating stall-cycle performance counter.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_W    = DEF_REG_W,
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int LOAD_LAT = 1,   // >= 1; 1 gives the classic single bubble
  parameter int MD_LAT   = 32,  // >= 2
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     id_is_md,
  input  logic                     id_reads_hilo,
  input  logic [REG_W-1:0]         exe_dreg,
  input  logic                     exe_we,
  input  logic                     exe_is_load,
  input  logic                     flush,
  output logic                     stall_n,
  output logic                     pc_we,
  output logic                     ifid_we,
  output logic                     idex_bubble,
  output logic                     md_start,
  output logic                     md_busy,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int              LU_W    = cnt_width(LOAD_LAT);
  localparam logic [LU_W-1:0] LU_LOAD = LU_W'(LOAD_LAT - 1);

  logic [LU_W-1:0] lu_cnt;
  logic            src_match;
  logic            lu_hit;
  logic            md_hit;
  logic            stall;

  // Any used source slot that names the register the EXE load is fetching.
  // Store-data slots are flagged unused because they are forwarded later.
  always_comb begin
    src_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src[i*REG_W +: REG_W] == exe_dreg)) begin
        src_match = 1'b1;
      end
    end
  end

  // Only loads stall; ALU writers are forwarded and $zero is never a hazard.
  assign lu_hit = exe_we & exe_is_load & (exe_dreg != REG_W'(REG_ZERO)) & src_match;

  assign md_hit = md_busy & (id_is_md | id_reads_hilo);

  // A flush kills the ID instruction, so whatever it was waiting on is moot.
  assign stall = (lu_hit | (lu_cnt != '0) | md_hit) & ~flush;

  assign stall_n     = ~stall;
  assign pc_we       = stall_n;
  assign ifid_we     = stall_n;
  assign idex_bubble = stall | flush;

  // The MD unit only accepts an instruction that is actually leaving ID.
  assign md_start = ~md_busy & id_is_md & ~stall & ~flush;

  // Remaining extra load-use stall cycles. Once loaded, the load has moved
  // past EXE, so the match is not re-evaluated until the count drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_cnt <= '0;
    end else if (flush) begin
      lu_cnt <= '0;
    end else if (lu_cnt == '0) begin
      if (lu_hit) begin
        lu_cnt <= LU_LOAD;
      end
    end else begin
      lu_cnt <= lu_cnt - LU_W'(1);
    end
  end

  // Stall-cycle performance counter, pinned at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  md_busy_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .busy  (md_busy)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit. Two instances share one stimulus:
// dut_a has LOAD_LAT=1 / CNT_W=16, dut_b has LOAD_LAT=3 / CNT_W=4; both MD_LAT=4.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_is_md;
  logic        id_reads_hilo;
  logic [4:0]  exe_dreg;
  logic        exe_we;
  logic        exe_is_load;
  logic        flush;

  logic        a_stall_n, a_pc_we, a_ifid_we, a_bubble, a_md_start, a_md_busy;
  logic [15:0] a_count;
  logic        b_stall_n, b_pc_we, b_ifid_we, b_bubble, b_md_start, b_md_busy;
  logic [3:0]  b_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .REG_W(5), .NUM_SRC(2), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
    .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo), .exe_dreg(exe_dreg),
    .exe_we(exe_we), .exe_is_load(exe_is_load), .flush(flush),
    .stall_n(a_stall_n), .pc_we(a_pc_we), .ifid_we(a_ifid_we),
    .idex_bubble(a_bubble), .md_start(a_md_start), .md_busy(a_md_busy),
    .stall_count(a_count)
  );

  hazard_stall_unit #(
    .REG_W(5), .NUM_SRC(2), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
    .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo), .exe_dreg(exe_dreg),
    .exe_we(exe_we), .exe_is_load(exe_is_load), .flush(flush),
    .stall_n(b_stall_n), .pc_we(b_pc_we), .ifid_we(b_ifid_we),
    .idex_bubble(b_bubble), .md_start(b_md_start), .md_busy(b_md_busy),
    .stall_count(b_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let state settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_src        = '0;
    id_src_used   = '0;
    id_is_md      = 1'b0;
    id_reads_hilo = 1'b0;
    exe_dreg      = '0;
    exe_we        = 1'b0;
    exe_is_load   = 1'b0;
    flush         = 1'b0;
  endtask

  // lw $8 in EXE, ID reads $8 in slot 0.
  task automatic load_use_r8();
    exe_is_load = 1'b1;
    exe_we      = 1'b1;
    exe_dreg    = 5'd8;
    id_src      = {5'd0, 5'd8};
    id_src_used = 2'b01;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    #1;
    // Reset state
    check("rst_a_stall_n", a_stall_n, 1);
    check("rst_a_pc_we",   a_pc_we,   1);
    check("rst_a_ifid_we", a_ifid_we, 1);
    check("rst_a_bubble",  a_bubble,  0);
    check("rst_a_md_busy", a_md_busy, 0);
    check("rst_a_count",   a_count,   0);
    check("rst_b_stall_n", b_stall_n, 1);
    check("rst_b_count",   b_count,   0);
    rst_n = 1'b1;
    tick();

    // Load-use: a stalls 1 cycle, b stalls 3
    load_use_r8();
    #1;
    check("lu_c0_a_stall_n", a_stall_n, 0);
    check("lu_c0_a_bubble",  a_bubble,  1);
    check("lu_c0_a_pc_we",   a_pc_we,   0);
    check("lu_c0_b_stall_n", b_stall_n, 0);
    tick();
    idle_inputs();
    #1;
    check("lu_c1_a_stall_n", a_stall_n, 1);
    check("lu_c1_a_count",   a_count,   1);
    check("lu_c1_b_stall_n", b_stall_n, 0);
    check("lu_c1_b_count",   b_count,   1);
    tick();
    check("lu_c2_b_stall_n", b_stall_n, 0);
    check("lu_c2_b_bubble",  b_bubble,  1);
    tick();
    check("lu_c3_b_stall_n", b_stall_n, 1);
    check("lu_c3_b_count",   b_count,   3);
    check("lu_c3_a_count",   a_count,   1);

    // No-hazard patterns within one cycle
    exe_is_load = 1'b1; exe_we = 1'b1; exe_dreg = 5'd9;
    id_src = {5'd9, 5'd0}; id_src_used = 2'b01;
    #1;
    check("store_data_a_stall_n", a_stall_n, 1);
    check("store_data_b_stall_n", b_stall_n, 1);
    exe_dreg = 5'd0; id_src = '0; id_src_used = 2'b11;
    #1;
    check("zero_reg_a_stall_n", a_stall_n, 1);
    check("zero_reg_b_stall_n", b_stall_n, 1);
    exe_is_load = 1'b0; exe_dreg = 5'd8; id_src = {5'd0, 5'd8}; id_src_used = 2'b01;
    #1;
    check("alu_writer_a_stall_n", a_stall_n, 1);
    check("alu_writer_b_bubble",  b_bubble,  0);
    idle_inputs();
    tick();

    // MD occupancy and HI/LO interlock
    id_is_md = 1'b1;
    #1;
    check("md_c0_a_start", a_md_start, 1);
    check("md_c0_b_start", b_md_start, 1);
    tick();
    id_is_md = 1'b0;
    id_reads_hilo = 1'b1;
    #1;
    check("md_c1_a_start",   a_md_start, 0);
    check("md_c1_a_busy",    a_md_busy,  1);
    check("md_c1_a_stall_n", a_stall_n,  0);
    check("md_c1_b_stall_n", b_stall_n,  0);
    id_is_md = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("md_c%0d_a_busy", k),    a_md_busy,  1);
      check($sformatf("md_c%0d_a_stall_n", k), a_stall_n,  0);
      check($sformatf("md_c%0d_a_start", k),   a_md_start, 0);
    end
    tick();
    idle_inputs();
    id_reads_hilo = 1'b1;
    #1;
    check("md_c5_a_busy",    a_md_busy, 0);
    check("md_c5_a_stall_n", a_stall_n, 1);
    check("md_c5_b_stall_n", b_stall_n, 1);
    check("md_c5_a_count",   a_count,   5);
    check("md_c5_b_count",   b_count,   7);
    idle_inputs();
    tick();

    // Flush in the 2nd cycle of b's 3-cycle load stall, MD in flight
    id_is_md = 1'b1;
    #1;
    check("fl_c0_b_start", b_md_start, 1);
    tick();
    idle_inputs();
    load_use_r8();
    #1;
    check("fl_c1_b_stall_n", b_stall_n, 0);
    tick();
    idle_inputs();
    flush = 1'b1;
    #1;
    check("fl_c2_b_stall_n", b_stall_n, 1);
    check("fl_c2_b_bubble",  b_bubble,  1);
    check("fl_c2_a_bubble",  a_bubble,  1);
    check("fl_c2_b_count",   b_count,   8);
    tick();
    flush = 1'b0;
    #1;
    check("fl_c3_b_stall_n", b_stall_n, 1);
    check("fl_c3_b_bubble",  b_bubble,  0);
    check("fl_c3_b_count",   b_count,   8);
    check("fl_c3_b_busy",    b_md_busy, 1);
    tick();
    check("fl_c4_b_busy", b_md_busy, 1);
    tick();
    check("fl_c5_b_busy", b_md_busy, 0);
    check("fl_c5_a_count", a_count, 6);

    // Saturation: 20 continuous stall cycles
    load_use_r8();
    for (int k = 0; k < 20; k++) begin
      tick();
    end
    check("sat_b_count", b_count, 15);
    check("sat_a_count", a_count, 26);
    idle_inputs();
    tick();
    tick();
    check("sat_drain_b_stall_n", b_stall_n, 1);
    check("sat_drain_b_count",   b_count,   15);

    // Reset in the middle of an MD operation
    id_is_md = 1'b1;
    #1;
    check("rst_md_a_start", a_md_start, 1);
    tick();
    idle_inputs();
    check("rst_md_a_busy_pre", a_md_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_md_a_busy_sync", a_md_busy, 1);
    tick();
    check("rst_md_a_busy",    a_md_busy, 0);
    check("rst_md_b_busy",    b_md_busy, 0);
    check("rst_md_a_count",   a_count,   0);
    check("rst_md_b_count",   b_count,   0);
    check("rst_md_b_stall_n", b_stall_n, 1);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
